// File: rtl/mux_pkg.sv
// Shared constants and pointer arithmetic for the N-to-1 selector/arbiter.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Wide enough for any index sum up to 2*64-2.
  localparam int PTR_W = 7;

  function automatic logic [PTR_W-1:0] wrap_mod(input logic [PTR_W-1:0] v,
                                               input logic [PTR_W-1:0] n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, modulo N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 16,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx
);

  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Descending scan so the candidate closest to ptr is the last one kept.
    for (int k = N - 1; k >= 0; k--) begin
      cand = wrap_mod(PTR_W'({1'b0, ptr}) + PTR_W'(k), PTR_W'(N));
      if (en && req[cand[SW-1:0]]) begin
        idx   = cand[SW-1:0];
        found = 1'b1;
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 selector with registered output, explicit-select or round-robin grant,
// and valid/ready handshakes on every channel.
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter int N  = 16,
  parameter int W  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           out_valid,
  input  logic           out_ready
);

  logic          load;
  logic [N-1:0]  sel_mask;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [SW-1:0] gnt_idx;
  logic          gnt_any;
  logic [W-1:0]  data_d;
  logic [SW:0]   ptr_inc;
  logic [SW-1:0] ptr_d, ptr_q;
  logic [W-1:0]  data_q;
  logic [SW-1:0] src_q;
  logic          valid_q;

  assign load = !valid_q || out_ready;

  // Out-of-range select (non-power-of-2 N) simply requests nothing.
  always_comb begin
    sel_mask = '0;
    if ({1'b0, sel} < (SW+1)'(N)) sel_mask[sel] = 1'b1;
  end

  assign req = (mode == MODE_RR) ? in_valid : (in_valid & sel_mask);

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .en  (load && !rst),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign gnt_any  = |gnt;
  assign in_ready = gnt;

  always_comb begin
    data_d = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) data_d = in_data[i*W +: W];
    end
  end

  assign ptr_inc = {1'b0, gnt_idx} + (SW+1)'(1);

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any && mode == MODE_RR)
      ptr_d = SW'(wrap_mod(PTR_W'(ptr_inc), PTR_W'(N)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        valid_q <= gnt_any;
        if (gnt_any) begin
          data_q <= data_d;
          src_q  <= gnt_idx;
        end
      end
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Randomised and directed checks of mux_arb_nto1 against a behavioural model.
module tb_mux_arb_nto1;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int SW = 4;
  localparam int N5  = 5;
  localparam int W5  = 8;
  localparam int SW5 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [SW-1:0]  sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_valid, out_ready;

  logic             b_rst;
  logic [N5*W5-1:0] b_in_data;
  logic [N5-1:0]    b_in_valid, b_in_ready;
  logic [SW5-1:0]   b_sel;
  logic             b_mode;
  logic [W5-1:0]    b_out_data;
  logic [SW5-1:0]   b_out_src;
  logic             b_out_valid, b_out_ready;

  mux_arb_nto1 #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_arb_nto1 #(.N(N5), .W(W5)) dut5 (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
    .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: output register contents plus the round-robin pointer.
  logic [W-1:0] chan [N];
  int           m_valid, m_src, m_ptr;
  logic [W-1:0] m_data;

  function automatic int model_grant();
    if (rst) return -1;
    if (m_valid != 0 && !out_ready) return -1;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input string tag);
    int g;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = chan[i];
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (m_valid == 0 || out_ready) begin
      if (g >= 0) begin
        m_valid = 1; m_data = chan[g]; m_src = g;
        if (mode) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    check_eq({tag, ".out_src"},   64'(out_src),   64'(m_src));
    check_eq({tag, ".out_data"},  64'(out_data),  64'(m_data));
    @(negedge clk);
  endtask

  initial begin
    b_rst = 1'b1; b_mode = 1'b0; b_sel = '0; b_in_valid = '0; b_out_ready = 1'b0;
    for (int i = 0; i < N5; i++) b_in_data[i*W5 +: W5] = W5'(i + 8'h10);
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) chan[i] = W'(i);
    m_valid = 0; m_src = 0; m_ptr = 0; m_data = '0;
    @(negedge clk);

    cycle("reset");
    cycle("reset");

    rst = 1'b0; in_valid = '1; out_ready = 1'b1;
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      cycle("sel_sweep");
    end

    sel = SW'(5); in_valid = 16'hFFDF;
    cycle("sel_idle");
    cycle("sel_idle");
    in_valid[5] = 1'b1;
    cycle("sel_wake");
    cycle("sel_wake");

    mode = 1'b1; in_valid = 16'hFFFF;
    for (int c = 0; c < 32; c++) cycle("rr_all");
    in_valid = 16'h8421;
    for (int c = 0; c < 5; c++) cycle("rr_sparse");

    in_valid = 16'h0006; out_ready = 1'b1;
    cycle("bp_first");
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle("bp_stall");
    out_ready = 1'b1;
    cycle("bp_release");
    cycle("bp_release");

    out_ready = 1'b0; in_valid = 16'hFFFF;
    cycle("mid_stall");
    rst = 1'b1;
    cycle("mid_rst");
    rst = 1'b0; out_ready = 1'b1;
    cycle("post_rst");

    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) chan[i] = $urandom;
      in_valid  = ($urandom_range(0, 1) != 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      mode      = ($urandom_range(0, 3) != 0);
      sel       = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      cycle("random");
    end
    rst = 1'b0;

    // Non-power-of-2 channel count.
    @(posedge clk); #1;
    b_rst = 1'b0; b_mode = 1'b1; b_in_valid = 5'b10001; b_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_eq("n5_rr.out_src", 64'(b_out_src), (c % 2 == 0) ? 64'd0 : 64'd4);
      check_eq("n5_rr.out_data", 64'(b_out_data), (c % 2 == 0) ? 64'h10 : 64'h14);
      check_eq("n5_rr.out_valid", 64'(b_out_valid), 64'd1);
    end
    @(negedge clk);
    b_mode = 1'b0; b_sel = 3'd6; b_in_valid = 5'b11111;
    #1;
    check_eq("n5_sel6.in_ready", 64'(b_in_ready), 64'd0);
    @(posedge clk); #1;
    check_eq("n5_sel6.out_valid", 64'(b_out_valid), 64'd0);
    check_eq("n5_sel6.no_x", 64'($isunknown({b_out_data, b_out_src, b_in_ready})), 64'd0);
    check_eq("n5_sel6.hold_data", 64'(b_out_data), 64'h14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
